// File: rtl/apb_gpio_pkg.sv
// Shared constants for the APB GPIO block: register offsets, IRQ polarity reset
// value and the address helper used by the register decode.
package apb_gpio_pkg;

    localparam logic [4:0] OFF_DATA_OUT = 5'h00;
    localparam logic [4:0] OFF_SET      = 5'h04;
    localparam logic [4:0] OFF_CLR      = 5'h08;
    localparam logic [4:0] OFF_DATA_IN  = 5'h0C;
    localparam logic [4:0] OFF_DIR      = 5'h10;
    localparam logic [4:0] OFF_IRQ_EN   = 5'h14;
    localparam logic [4:0] OFF_IRQ_STAT = 5'h18;
    localparam logic [4:0] OFF_IRQ_POL  = 5'h1C;

    // All pins default to rising-edge interrupts.
    localparam logic [31:0] IRQ_POL_RST = 32'hFFFF_FFFF;

    // Byte address to word-aligned register offset.
    function automatic logic [4:0] word_addr(input logic [4:0] paddr);
        return paddr & 5'b11100;
    endfunction

endpackage

// File: rtl/apb_gpio_if.sv
// APB slave-side bus bundle for apb_gpio (no PREADY/PSLVERR: zero wait states).
interface apb_gpio_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA
    );

endinterface

// File: rtl/gpio_sync.sv
// WIDTH x STAGES flop-chain synchroniser for asynchronous pin inputs; q is the
// last stage. Chain clears asynchronously on nRESET.
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             PCLK,
    input  logic             nRESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge PCLK or negedge nRESET) begin
        if (!nRESET) chain <= '0;
        else         chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/apb_gpio.sv
// APB GPIO: output data/direction registers, synchronised input readback and,
// when APB_GPIO_IRQ_EN is defined, per-pin edge interrupts with polarity select.
module apb_gpio
    import apb_gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             nRESET,
    apb_gpio_if.slave        bus,
    output logic [WIDTH-1:0] outport,
    output logic [WIDTH-1:0] oe,
    input  logic [WIDTH-1:0] inport,
    output logic             irq
);

    logic             wr_en;
    logic [4:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] sync_in;
    logic [31:0]      rdata;
    logic             unused_ok;

    assign wr_en = bus.PSEL & bus.PENABLE & bus.PWRITE;
    assign waddr = word_addr(bus.PADDR);
    assign wdata = bus.PWDATA[WIDTH-1:0];

    // PWDATA bits above WIDTH are intentionally dropped.
    assign unused_ok = &{1'b0, bus.PWDATA};

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .PCLK   (PCLK),
        .nRESET (nRESET),
        .d      (inport),
        .q      (sync_in)
    );

    always_ff @(posedge PCLK or negedge nRESET) begin
        if (!nRESET) begin
            data_out <= RESET_VALUE;
        end else if (wr_en) begin
            case (waddr)
                OFF_DATA_OUT: data_out <= wdata;
                OFF_SET:      data_out <= data_out | wdata;
                OFF_CLR:      data_out <= data_out & ~wdata;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge nRESET) begin
        if (!nRESET)                         dir <= '0;
        else if (wr_en && waddr == OFF_DIR)  dir <= wdata;
    end

`ifdef APB_GPIO_IRQ_EN
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_stat;
    logic [WIDTH-1:0] irq_pol;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] stat_clr;

    // An event needs a real change of the synchronised pin; a polarity write
    // alone never matches because sync == prev.
    assign evt      = (sync_in ^ prev) & ~(sync_in ^ irq_pol);
    assign stat_clr = (wr_en && waddr == OFF_IRQ_STAT) ? wdata : '0;

    always_ff @(posedge PCLK or negedge nRESET) begin
        if (!nRESET) begin
            prev     <= '0;
            irq_en   <= '0;
            irq_pol  <= IRQ_POL_RST[WIDTH-1:0];
            irq_stat <= '0;
        end else begin
            prev     <= sync_in;
            // Set has priority over a coincident W1C.
            irq_stat <= (irq_stat & ~stat_clr) | evt;
            if (wr_en && waddr == OFF_IRQ_EN)  irq_en  <= wdata;
            if (wr_en && waddr == OFF_IRQ_POL) irq_pol <= wdata;
        end
    end

    assign irq = |(irq_stat & irq_en);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (waddr)
            OFF_DATA_OUT: rdata[WIDTH-1:0] = data_out;
            OFF_DATA_IN:  rdata[WIDTH-1:0] = sync_in;
            OFF_DIR:      rdata[WIDTH-1:0] = dir;
`ifdef APB_GPIO_IRQ_EN
            OFF_IRQ_EN:   rdata[WIDTH-1:0] = irq_en;
            OFF_IRQ_STAT: rdata[WIDTH-1:0] = irq_stat;
            OFF_IRQ_POL:  rdata[WIDTH-1:0] = irq_pol;
`endif
            default:      ;
        endcase
    end

    assign bus.PRDATA = rdata;
    assign outport    = data_out;
    assign oe         = dir;

endmodule
